riscv_mmio_arbiter: RTL and testbench
=====================================

RISCV_MMIO_ARBITER -- requirements
Module: riscv_mmio_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named HCLK and HRESETn.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- MASTERS, 4, number of AHB-Lite masters.
- HADDR_SIZE, 32, address width.
- HDATA_SIZE, 32, data width.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- HCLK, in, 1, clock.
- HRESETn, in, 1, asynchronous active-low reset.
- mst_HTRANS, in, [MASTERS][2], per-master transfer type.
- mst_HADDR, in, [MASTERS][HADDR_SIZE], per-master address.
- mst_HWRITE, in, [MASTERS], per-master write flag.
- mst_HSIZE, in, [MASTERS][3], per-master transfer size.
- mst_HBURST, in, [MASTERS][3], per-master burst type.
- mst_HWDATA, in, [MASTERS][HDATA_SIZE], per-master write data.
- mst_HRDATA, out, [MASTERS][HDATA_SIZE], per-master read data.
- mst_HREADY, out, [MASTERS], per-master ready.
- mst_HRESP, out, [MASTERS], per-master response.
- slv_HTRANS, slv_HADDR, slv_HWRITE, slv_HSIZE, slv_HBURST, slv_HWDATA, out, same widths unindexed, shared MMIO slave request.
- slv_HRDATA, in, HDATA_SIZE, slave read data.
- slv_HREADY, in, 1, slave ready.
- slv_HRESP, in, 1, slave response.

Function
REQ-004 When mst_HREADY[m]=1 and mst_HTRANS[m] is NONSEQ or SEQ, the block SHALL capture HADDR/HWRITE/HSIZE/HBURST/HTRANS of master m into a per-master pending register at that edge.
REQ-005 Each master SHALL have a state machine with states IDLE, PEND and DATA.
- IDLE->PEND on capture.
- PEND->DATA when master m is granted and slv_HREADY=1.
- DATA->IDLE when slv_HREADY=1.
- DATA->PEND when slv_HREADY=1 and a new request is captured in the same cycle.
REQ-006 mst_HREADY[m] SHALL be 1 in IDLE, 0 in PEND, and equal to slv_HREADY in DATA.
REQ-007 In DATA, mst_HRDATA[m] and mst_HRESP[m] SHALL equal slv_HRDATA and slv_HRESP combinationally; in IDLE/PEND they SHALL be 0 and OKAY.
REQ-008 Grant SHALL be evaluated only in cycles with slv_HREADY=1, and SHALL be round-robin among masters in PEND, starting after the last granted master.
REQ-009 While a granted master's pending transfer is SEQ, the grant SHALL stay with that master (burst lock); lock SHALL release on a NONSEQ or IDLE from that master.
REQ-010 The slave address phase SHALL be driven from the granted pending register; when no master is in PEND, slv_HTRANS SHALL be IDLE.
REQ-011 slv_HWDATA SHALL equal mst_HWDATA of the master in DATA, and 0 when no master is in DATA.
REQ-012 One master in DATA and another's address phase on the slave in the same cycle SHALL be supported (pipelined overlap).
REQ-013 Uncontested latency SHALL be: capture at edge N, slave address phase in cycle N+1, slave data phase in cycle N+2, mst_HREADY high at end of N+2 for a zero-wait slave.
REQ-014 A two-cycle ERROR (slv_HRESP=ERROR, slv_HREADY 0 then 1) SHALL pass to the owning master unchanged, and any address phase issued during the first ERROR cycle SHALL be replaced by IDLE.
REQ-015 A master in PEND that drives IDLE SHALL NOT cancel its captured transfer.

Reset
REQ-016 On HRESETn low, asynchronously:
- all masters SHALL go to IDLE;
- mst_HREADY SHALL be all 1, mst_HRESP OKAY, mst_HRDATA 0;
- slv_HTRANS SHALL be IDLE and all other slv_* outputs 0;
- the round-robin pointer SHALL be 0 and the burst lock SHALL be cleared.
REQ-017 Reset mid-transfer SHALL discard all pending and data-phase ownership with no slave access issued after release until a new capture.

Structure
REQ-018 The HTRANS/HRESP constants and the per-master state enum SHALL live in riscv_mpsoc_pkg.
REQ-019 Round-robin selection SHALL be a sub-module riscv_mmio_rr_arbiter (MASTERS request bits in; one-hot grant and pointer update out).

Verification
REQ-020 The bench SHALL cover these scenarios:
- Single master 0 writes 0x00000001 to 0x80001000 with a zero-wait slave -> slave sees NONSEQ at N+1; mst_HREADY[0] is low in N+1 and high at end of N+2.
- Masters 0..3 issue NONSEQ in the same cycle -> slave grant order is 0,1,2,3, then 1,2,3,0 after master 0 repeats.
- Master 2 does an INCR4 read while master 1 requests -> four SEQ beats of master 2 are contiguous and master 1 is granted after.
- Slave inserts 3 wait states on master 0's data phase -> master 1's address stays on the slave bus, and mst_HREADY[0] is low for 3 cycles.
- Slave returns ERROR to master 3 -> mst_HRESP[3] is ERROR for 2 cycles, and slv_HTRANS is IDLE in the first cycle.
- HRESETn is asserted while master 0 is in PEND -> mst_HREADY is all 1 and slv_HTRANS is IDLE immediately, with no transfer after release.

Source files
------------

// File: rtl/riscv_mpsoc_pkg.sv
// Shared AHB-Lite encodings and per-master arbitration state for the MMIO arbiter.
package riscv_mpsoc_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        MST_IDLE = 2'd0,
        MST_PEND = 2'd1,
        MST_DATA = 2'd2
    } mst_state_e;

endpackage

// File: rtl/riscv_mmio_rr_arbiter.sv
// Round-robin picker: searches from ptr_i upward and returns a one-hot grant
// plus the pointer value (one past the winner) to use for the next decision.
module riscv_mmio_rr_arbiter
    import riscv_mpsoc_pkg::*;
#(
    parameter  int MASTERS = 4,
    localparam int PW      = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic [MASTERS-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [MASTERS-1:0] gnt_o,
    output logic [PW-1:0]      ptr_nxt_o
);

    int   idx;
    logic found;

    always_comb begin
        gnt_o     = '0;
        ptr_nxt_o = ptr_i;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < MASTERS; k++) begin
            idx = (int'(ptr_i) + k) % MASTERS;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_nxt_o  = PW'((idx + 1) % MASTERS);
            end
        end
    end

endmodule

// File: rtl/riscv_mmio_arbiter.sv
// Multi-master AHB-Lite to single MMIO slave arbiter: per-master request capture,
// round-robin grant with burst lock, and overlapped address/data phases.
module riscv_mmio_arbiter
    import riscv_mpsoc_pkg::*;
#(
    parameter int MASTERS    = 4,
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
) (
    input  logic                                HCLK,
    input  logic                                HRESETn,
    input  logic [MASTERS-1:0][1:0]             mst_HTRANS,
    input  logic [MASTERS-1:0][HADDR_SIZE-1:0]  mst_HADDR,
    input  logic [MASTERS-1:0]                  mst_HWRITE,
    input  logic [MASTERS-1:0][2:0]             mst_HSIZE,
    input  logic [MASTERS-1:0][2:0]             mst_HBURST,
    input  logic [MASTERS-1:0][HDATA_SIZE-1:0]  mst_HWDATA,
    output logic [MASTERS-1:0][HDATA_SIZE-1:0]  mst_HRDATA,
    output logic [MASTERS-1:0]                  mst_HREADY,
    output logic [MASTERS-1:0]                  mst_HRESP,
    output logic [1:0]                          slv_HTRANS,
    output logic [HADDR_SIZE-1:0]               slv_HADDR,
    output logic                                slv_HWRITE,
    output logic [2:0]                          slv_HSIZE,
    output logic [2:0]                          slv_HBURST,
    output logic [HDATA_SIZE-1:0]               slv_HWDATA,
    input  logic [HDATA_SIZE-1:0]               slv_HRDATA,
    input  logic                                slv_HREADY,
    input  logic                                slv_HRESP
);

    localparam int PW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    mst_state_e state_q [MASTERS];
    mst_state_e state_d [MASTERS];

    logic [MASTERS-1:0][HADDR_SIZE-1:0] pend_haddr_q;
    logic [MASTERS-1:0]                 pend_hwrite_q;
    logic [MASTERS-1:0][2:0]            pend_hsize_q;
    logic [MASTERS-1:0][2:0]            pend_hburst_q;
    logic [MASTERS-1:0][1:0]            pend_htrans_q;

    logic [PW-1:0] rr_ptr_q, rr_ptr_d, ptr_nxt;
    logic [PW-1:0] hold_own_q, hold_own_d, lock_own_q, lock_own_d, sel;
    logic          hold_q, hold_d, lock_q, lock_d;
    logic [MASTERS-1:0] cap, pend_vec, data_vec, req, gnt;
    logic          addr_vld, accept, err_first;

    always_comb begin
        for (int m = 0; m < MASTERS; m++) begin
            pend_vec[m]   = (state_q[m] == MST_PEND);
            data_vec[m]   = (state_q[m] == MST_DATA);
            mst_HREADY[m] = (state_q[m] == MST_IDLE) || (data_vec[m] && slv_HREADY);
            mst_HRDATA[m] = data_vec[m] ? slv_HRDATA : '0;
            mst_HRESP[m]  = data_vec[m] ? slv_HRESP : HRESP_OKAY;
            cap[m]        = mst_HREADY[m] &&
                            (mst_HTRANS[m] == HTRANS_NONSEQ || mst_HTRANS[m] == HTRANS_SEQ);
        end
    end

    // A locked burst owner excludes everyone else; an address stalled by wait
    // states keeps its owner until the slave accepts it.
    always_comb begin
        req = '0;
        if (lock_q) begin
            req[lock_own_q] = pend_vec[lock_own_q];
        end else if (hold_q) begin
            req[hold_own_q] = 1'b1;
        end else begin
            req = pend_vec;
        end
    end

    riscv_mmio_rr_arbiter #(
        .MASTERS (MASTERS)
    ) u_rr (
        .req_i     (req),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .ptr_nxt_o (ptr_nxt)
    );

    always_comb begin
        sel = '0;
        for (int k = 0; k < MASTERS; k++) begin
            if (gnt[k]) sel = PW'(k);
        end
        err_first = (slv_HRESP == HRESP_ERROR) && !slv_HREADY;
        addr_vld  = (|gnt) && !err_first;
        accept    = addr_vld && slv_HREADY;
    end

    always_comb begin
        slv_HTRANS = HTRANS_IDLE;
        slv_HADDR  = '0;
        slv_HWRITE = 1'b0;
        slv_HSIZE  = '0;
        slv_HBURST = '0;
        slv_HWDATA = '0;
        if (addr_vld) begin
            slv_HTRANS = pend_htrans_q[sel];
            slv_HADDR  = pend_haddr_q[sel];
            slv_HWRITE = pend_hwrite_q[sel];
            slv_HSIZE  = pend_hsize_q[sel];
            slv_HBURST = pend_hburst_q[sel];
        end
        for (int k = 0; k < MASTERS; k++) begin
            if (data_vec[k]) slv_HWDATA = mst_HWDATA[k];
        end
    end

    always_comb begin
        for (int m = 0; m < MASTERS; m++) begin
            state_d[m] = state_q[m];
            case (state_q[m])
                MST_IDLE: if (cap[m]) state_d[m] = MST_PEND;
                MST_PEND: if (accept && gnt[m]) state_d[m] = MST_DATA;
                MST_DATA: if (slv_HREADY) state_d[m] = cap[m] ? MST_PEND : MST_IDLE;
                default:  state_d[m] = MST_IDLE;
            endcase
        end
        hold_d     = addr_vld && !slv_HREADY;
        hold_own_d = sel;
        rr_ptr_d   = accept ? ptr_nxt : rr_ptr_q;
        lock_d     = lock_q;
        lock_own_d = lock_own_q;
        if (accept) begin
            lock_d     = (pend_hburst_q[sel] != HBURST_SINGLE);
            lock_own_d = sel;
        end else if (lock_q && data_vec[lock_own_q] && slv_HREADY &&
                     !(cap[lock_own_q] && mst_HTRANS[lock_own_q] == HTRANS_SEQ)) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int m = 0; m < MASTERS; m++) state_q[m] <= MST_IDLE;
            rr_ptr_q   <= '0;
            hold_q     <= 1'b0;
            hold_own_q <= '0;
            lock_q     <= 1'b0;
            lock_own_q <= '0;
        end else begin
            for (int m = 0; m < MASTERS; m++) state_q[m] <= state_d[m];
            rr_ptr_q   <= rr_ptr_d;
            hold_q     <= hold_d;
            hold_own_q <= hold_own_d;
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
        end
    end

    // Payload registers are only observed through PEND ownership, so they skip reset.
    always_ff @(posedge HCLK) begin
        for (int m = 0; m < MASTERS; m++) begin
            if (cap[m]) begin
                pend_haddr_q[m]  <= mst_HADDR[m];
                pend_hwrite_q[m] <= mst_HWRITE[m];
                pend_hsize_q[m]  <= mst_HSIZE[m];
                pend_hburst_q[m] <= mst_HBURST[m];
                pend_htrans_q[m] <= mst_HTRANS[m];
            end
        end
    end

endmodule

// File: tb/tb_riscv_mmio_arbiter.sv
// Directed bench for riscv_mmio_arbiter: latency, round-robin, burst lock,
// wait states, error response and mid-transfer reset.
module tb_riscv_mmio_arbiter;

    localparam int M  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                  HCLK = 1'b0;
    logic                  HRESETn;
    logic [M-1:0][1:0]     mst_HTRANS;
    logic [M-1:0][AW-1:0]  mst_HADDR;
    logic [M-1:0]          mst_HWRITE;
    logic [M-1:0][2:0]     mst_HSIZE;
    logic [M-1:0][2:0]     mst_HBURST;
    logic [M-1:0][DW-1:0]  mst_HWDATA;
    logic [M-1:0][DW-1:0]  mst_HRDATA;
    logic [M-1:0]          mst_HREADY;
    logic [M-1:0]          mst_HRESP;
    logic [1:0]            slv_HTRANS;
    logic [AW-1:0]         slv_HADDR;
    logic                  slv_HWRITE;
    logic [2:0]            slv_HSIZE;
    logic [2:0]            slv_HBURST;
    logic [DW-1:0]         slv_HWDATA;
    logic [DW-1:0]         slv_HRDATA;
    logic                  slv_HREADY;
    logic                  slv_HRESP;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] log_addr[$];
    logic [1:0]    log_trans[$];

    always #5 HCLK = ~HCLK;

    riscv_mmio_arbiter #(.MASTERS(M), .HADDR_SIZE(AW), .HDATA_SIZE(DW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .mst_HTRANS(mst_HTRANS), .mst_HADDR(mst_HADDR), .mst_HWRITE(mst_HWRITE),
        .mst_HSIZE(mst_HSIZE), .mst_HBURST(mst_HBURST), .mst_HWDATA(mst_HWDATA),
        .mst_HRDATA(mst_HRDATA), .mst_HREADY(mst_HREADY), .mst_HRESP(mst_HRESP),
        .slv_HTRANS(slv_HTRANS), .slv_HADDR(slv_HADDR), .slv_HWRITE(slv_HWRITE),
        .slv_HSIZE(slv_HSIZE), .slv_HBURST(slv_HBURST), .slv_HWDATA(slv_HWDATA),
        .slv_HRDATA(slv_HRDATA), .slv_HREADY(slv_HREADY), .slv_HRESP(slv_HRESP)
    );

    // Record every address phase the slave accepts.
    always @(negedge HCLK) begin
        if (HRESETn === 1'b1 && slv_HREADY && slv_HTRANS != 2'b00) begin
            log_addr.push_back(slv_HADDR);
            log_trans.push_back(slv_HTRANS);
        end
    end

    task automatic nxt();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_all();
        for (int m = 0; m < M; m++) begin
            mst_HTRANS[m] = 2'b00;
            mst_HBURST[m] = 3'b000;
        end
    endtask

    task automatic req(input int m, input logic [1:0] tr, input logic [AW-1:0] a,
                       input logic wr, input logic [2:0] burst);
        mst_HTRANS[m] = tr;
        mst_HADDR[m]  = a;
        mst_HWRITE[m] = wr;
        mst_HSIZE[m]  = 3'b010;
        mst_HBURST[m] = burst;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        idle_all();
        nxt();
        nxt();
        HRESETn = 1'b1;
        log_addr.delete();
        log_trans.delete();
    endtask

    task automatic test_reset();
        HRESETn    = 1'b0;
        idle_all();
        mst_HADDR  = '0;
        mst_HWRITE = '0;
        mst_HSIZE  = '0;
        mst_HWDATA = '0;
        slv_HRDATA = 32'hCAFE_0000;
        slv_HREADY = 1'b1;
        slv_HRESP  = 1'b0;
        #3;
        checks++; if (mst_HREADY !== 4'hF) begin errors++; $display("FAIL rst_hready got %h exp f", mst_HREADY); end
        checks++; if (mst_HRESP !== 4'h0) begin errors++; $display("FAIL rst_hresp got %h exp 0", mst_HRESP); end
        checks++; if (mst_HRDATA !== '0) begin errors++; $display("FAIL rst_hrdata got %h exp 0", mst_HRDATA); end
        checks++; if (slv_HTRANS !== 2'b00) begin errors++; $display("FAIL rst_slv_htrans got %h exp 0", slv_HTRANS); end
        checks++; if (slv_HADDR !== '0 || slv_HWDATA !== '0 || slv_HWRITE !== 1'b0)
            begin errors++; $display("FAIL rst_slv_bus got %h/%h/%b exp 0", slv_HADDR, slv_HWDATA, slv_HWRITE); end
        nxt();
        nxt();
        HRESETn = 1'b1;
    endtask

    task automatic test_single_write();
        do_reset();
        nxt();
        req(0, 2'b10, 32'h8000_1000, 1'b1, 3'b000);
        #1;
        checks++; if (mst_HREADY[0] !== 1'b1) begin errors++; $display("FAIL wr_idle_ready got %b exp 1", mst_HREADY[0]); end
        nxt();
        mst_HTRANS[0] = 2'b00;
        mst_HWDATA[0] = 32'h0000_0001;
        #1;
        checks++; if (slv_HTRANS !== 2'b10) begin errors++; $display("FAIL wr_n1_trans got %h exp 2", slv_HTRANS); end
        checks++; if (slv_HADDR !== 32'h8000_1000 || slv_HWRITE !== 1'b1)
            begin errors++; $display("FAIL wr_n1_addr got %h/%b exp 80001000/1", slv_HADDR, slv_HWRITE); end
        checks++; if (mst_HREADY[0] !== 1'b0) begin errors++; $display("FAIL wr_n1_ready got %b exp 0", mst_HREADY[0]); end
        nxt();
        checks++; if (mst_HREADY[0] !== 1'b1) begin errors++; $display("FAIL wr_n2_ready got %b exp 1", mst_HREADY[0]); end
        checks++; if (slv_HWDATA !== 32'h0000_0001) begin errors++; $display("FAIL wr_n2_wdata got %h exp 1", slv_HWDATA); end
        checks++; if (slv_HTRANS !== 2'b00) begin errors++; $display("FAIL wr_n2_trans got %h exp 0", slv_HTRANS); end
        nxt();
        checks++; if (slv_HWDATA !== '0) begin errors++; $display("FAIL wr_n3_wdata got %h exp 0", slv_HWDATA); end
    endtask

    task automatic test_round_robin();
        int exp_id [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        logic [AW-1:0] a;
        do_reset();
        nxt();
        for (int m = 0; m < M; m++) req(m, 2'b10, 32'h8000_0000 | (m << 12), 1'b1, 3'b000);
        nxt(); idle_all();
        repeat (6) nxt();
        req(0, 2'b10, 32'h8000_0000, 1'b1, 3'b000);
        nxt(); idle_all();
        repeat (4) nxt();
        for (int m = 0; m < M; m++) req(m, 2'b10, 32'h8000_0000 | (m << 12), 1'b1, 3'b000);
        nxt(); idle_all();
        repeat (6) nxt();
        checks++; if (log_addr.size() != 9) begin errors++; $display("FAIL rr_count got %0d exp 9", log_addr.size()); end
        for (int i = 0; i < 9; i++) begin
            a = (i < log_addr.size()) ? log_addr[i] : 32'hFFFF_FFFF;
            checks++;
            if (a !== (32'h8000_0000 | (exp_id[i] << 12)))
                begin errors++; $display("FAIL rr_order[%0d] got %h exp master %0d", i, a, exp_id[i]); end
        end
    endtask

    task automatic test_burst_lock();
        logic [AW-1:0] exp_a [5] = '{32'h8000_2000, 32'h8000_2004, 32'h8000_2008, 32'h8000_200C, 32'h8000_1000};
        logic [1:0]    exp_t [5] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10};
        int beats;
        do_reset();
        nxt();
        req(2, 2'b10, 32'h8000_2000, 1'b0, 3'b011);
        beats = 1;
        for (int c = 0; c < 14; c++) begin
            nxt();
            if (c == 0) req(1, 2'b10, 32'h8000_1000, 1'b0, 3'b000);
            else mst_HTRANS[1] = 2'b00;
            if (mst_HREADY[2]) begin
                if (beats < 4) begin
                    req(2, 2'b11, 32'h8000_2000 + 32'(4 * beats), 1'b0, 3'b011);
                    beats++;
                end else begin
                    mst_HTRANS[2] = 2'b00;
                end
            end
            #1;
            if (c == 1) begin
                checks++; if (mst_HRDATA[2] !== 32'hCAFE_0000 || mst_HRDATA[1] !== '0)
                    begin errors++; $display("FAIL burst_rdata got %h/%h exp cafe0000/0", mst_HRDATA[2], mst_HRDATA[1]); end
            end
        end
        checks++; if (log_addr.size() != 5) begin errors++; $display("FAIL burst_count got %0d exp 5", log_addr.size()); end
        for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== exp_a[i] || log_trans[i] !== exp_t[i])
                begin errors++; $display("FAIL burst_beat[%0d] got %h/%h exp %h/%h", i, log_addr[i], log_trans[i], exp_a[i], exp_t[i]); end
        end
    endtask

    task automatic test_wait_states();
        int low;
        do_reset();
        nxt();
        req(0, 2'b10, 32'h8000_0000, 1'b1, 3'b000);
        req(1, 2'b10, 32'h8000_1000, 1'b1, 3'b000);
        nxt(); idle_all();
        mst_HWDATA[0] = 32'h0000_0011;
        #1;
        checks++; if (slv_HADDR !== 32'h8000_0000) begin errors++; $display("FAIL ws_first_addr got %h exp 80000000", slv_HADDR); end
        low = 0;
        for (int w = 0; w < 3; w++) begin
            nxt();
            slv_HREADY = 1'b0;
            #1;
            if (mst_HREADY[0] === 1'b0) low++;
            checks++; if (slv_HTRANS !== 2'b10 || slv_HADDR !== 32'h8000_1000)
                begin errors++; $display("FAIL ws_hold[%0d] got %h/%h exp 2/80001000", w, slv_HTRANS, slv_HADDR); end
        end
        checks++; if (slv_HWDATA !== 32'h0000_0011) begin errors++; $display("FAIL ws_wdata got %h exp 11", slv_HWDATA); end
        nxt();
        slv_HREADY = 1'b1;
        #1;
        checks++; if (low != 3 || mst_HREADY[0] !== 1'b1)
            begin errors++; $display("FAIL ws_ready0 got low=%0d rdy=%b exp 3/1", low, mst_HREADY[0]); end
        nxt();
        checks++; if (mst_HREADY[1] !== 1'b1 || mst_HREADY[0] !== 1'b1)
            begin errors++; $display("FAIL ws_m1_data got %b exp 11", mst_HREADY[1:0]); end
    endtask

    task automatic test_error();
        do_reset();
        nxt();
        req(3, 2'b10, 32'h8000_3000, 1'b1, 3'b000);
        nxt();
        mst_HTRANS[3] = 2'b00;
        req(0, 2'b10, 32'h8000_0000, 1'b1, 3'b000);
        nxt();
        mst_HTRANS[0] = 2'b00;
        slv_HRESP  = 1'b1;
        slv_HREADY = 1'b0;
        #1;
        checks++; if (mst_HRESP[3] !== 1'b1 || mst_HREADY[3] !== 1'b0)
            begin errors++; $display("FAIL err_c1_m3 got resp=%b rdy=%b exp 1/0", mst_HRESP[3], mst_HREADY[3]); end
        checks++; if (slv_HTRANS !== 2'b00) begin errors++; $display("FAIL err_c1_trans got %h exp 0", slv_HTRANS); end
        nxt();
        slv_HREADY = 1'b1;
        #1;
        checks++; if (mst_HRESP[3] !== 1'b1 || mst_HREADY[3] !== 1'b1 || mst_HRESP[0] !== 1'b0)
            begin errors++; $display("FAIL err_c2 got resp3=%b rdy3=%b resp0=%b exp 1/1/0", mst_HRESP[3], mst_HREADY[3], mst_HRESP[0]); end
        checks++; if (slv_HTRANS !== 2'b10 || slv_HADDR !== 32'h8000_0000)
            begin errors++; $display("FAIL err_c2_addr got %h/%h exp 2/80000000", slv_HTRANS, slv_HADDR); end
        nxt();
        slv_HRESP = 1'b0;
        #1;
        checks++; if (mst_HRESP[3] !== 1'b0 || mst_HREADY[0] !== 1'b1)
            begin errors++; $display("FAIL err_after got resp3=%b rdy0=%b exp 0/1", mst_HRESP[3], mst_HREADY[0]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        nxt();
        req(0, 2'b10, 32'h8000_0000, 1'b1, 3'b000);
        nxt();
        mst_HTRANS[0] = 2'b00;
        #1;
        checks++; if (mst_HREADY[0] !== 1'b0) begin errors++; $display("FAIL rstmid_pend got %b exp 0", mst_HREADY[0]); end
        HRESETn = 1'b0;
        #1;
        checks++; if (mst_HREADY !== 4'hF || slv_HTRANS !== 2'b00)
            begin errors++; $display("FAIL rstmid_async got %h/%h exp f/0", mst_HREADY, slv_HTRANS); end
        nxt();
        nxt();
        HRESETn = 1'b1;
        log_addr.delete();
        log_trans.delete();
        for (int c = 0; c < 5; c++) begin
            nxt();
            checks++; if (slv_HTRANS !== 2'b00) begin errors++; $display("FAIL rstmid_idle[%0d] got %h exp 0", c, slv_HTRANS); end
        end
        checks++; if (log_addr.size() != 0) begin errors++; $display("FAIL rstmid_nolog got %0d exp 0", log_addr.size()); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_burst_lock();
        test_wait_states();
        test_error();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
